spi_mem_responder: RTL and testbench

SPI responder (mode 0, MSB first) holding an internal byte-wide register memory that the SPI initiator writes and reads. All SPI inputs are oversampled in the single system clock domain: two-flop synchronisers followed by sclk edge detection. It reports each transaction's completion with a 1-cycle done pulse and an err pulse that only occurs together with done. It sits at the far end of the SPI link as the memory target for the initiator.

---
 rtl/spi_mem_responder.sv | 161 ++++++++++++++++
 tb/tb_spi_mem_responder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_mem_responder.sv
// SPI mode-0 responder with a DEPTH-byte register memory; 17-bit frames {op, addr[7:0], data[7:0]}.
// Optional write protect input wp is enabled by defining SPI_MEM_WR_PROTECT_EN.
module spi_mem_responder #(
  parameter int DEPTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sclk,
  input  logic cs_n,
  input  logic mosi,
`ifdef SPI_MEM_WR_PROTECT_EN
  input  logic wp,
`endif
  output logic miso,
  output logic done,
  output logic err
);

  localparam int         AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [8:0] DEPTH9 = 9'(DEPTH);

  typedef enum logic [2:0] {IDLE, ADDR, WDATA, RDATA, FINISH} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_d, cs_d;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_rise, sclk_fall, cs_fall;

  state_t     state;
  logic [3:0] cnt;
  logic [6:0] sr;
  logic       op_q;
  logic [7:0] addr_q;
  logic [7:0] tx;
  logic [7:0] mem [DEPTH];

  logic [7:0] addr_nx, data_nx;
  logic       nx_in_range, in_range, wr_block;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_fall   = cs_d & ~cs_s;

  assign addr_nx     = {sr, mosi_s};
  assign data_nx     = {sr, mosi_s};
  assign nx_in_range = ({1'b0, addr_nx} < DEPTH9);
  assign in_range    = ({1'b0, addr_q} < DEPTH9);
`ifdef SPI_MEM_WR_PROTECT_EN
  assign wr_block    = wp;
`else
  assign wr_block    = 1'b0;
`endif

  // cs_n synchroniser resets low so a select already held low across reset
  // never looks like a falling edge; a frame needs a genuine high-to-low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      sr     <= '0;
      op_q   <= 1'b0;
      addr_q <= '0;
      tx     <= '0;
      miso   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          miso <= 1'b0;
          if (cs_fall) begin
            state <= ADDR;
            cnt   <= '0;
            sr    <= '0;
          end
        end
        ADDR, WDATA, RDATA: begin
          if (cs_s) begin
            state <= IDLE;
            done  <= 1'b1;
            err   <= 1'b1;
            miso  <= 1'b0;
          end else if (state == ADDR) begin
            if (sclk_rise) begin
              sr <= {sr[5:0], mosi_s};
              if (cnt == 4'd0) op_q <= mosi_s;
              if (cnt == 4'd8) begin
                addr_q <= addr_nx;
                cnt    <= '0;
                if (op_q) begin
                  state <= WDATA;
                end else begin
                  state <= RDATA;
                  tx    <= nx_in_range ? mem[addr_nx[AW-1:0]] : '0;
                end
              end else begin
                cnt <= cnt + 4'd1;
              end
            end
          end else if (state == WDATA) begin
            if (sclk_rise) begin
              sr <= {sr[5:0], mosi_s};
              if (cnt == 4'd7) begin
                if (in_range && !wr_block) mem[addr_q[AW-1:0]] <= data_nx;
                state <= FINISH;
                done  <= 1'b1;
                err   <= ~in_range | wr_block;
              end else begin
                cnt <= cnt + 4'd1;
              end
            end
          end else begin
            if (sclk_fall) begin
              miso <= tx[7];
              tx   <= {tx[6:0], 1'b0};
            end
            if (sclk_rise) begin
              if (cnt == 4'd7) begin
                state <= FINISH;
                done  <= 1'b1;
                err   <= ~in_range;
                miso  <= 1'b0;
              end else begin
                cnt <= cnt + 4'd1;
              end
            end
          end
        end
        FINISH: begin
          miso <= 1'b0;
          if (cs_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_mem_responder.sv
// Bench for spi_mem_responder: vector table of SPI frames plus hand-written corner sequences,
// done/err pulses checked against a scoreboard queue.
module tb_spi_mem_responder;

  logic clk, rst, sclk, cs_n, mosi;
  logic miso, done, err;
`ifdef SPI_MEM_WR_PROTECT_EN
  logic wp;
`endif

  spi_mem_responder #(.DEPTH(32), .SYNC_STAGES(2)) dut (
    .clk  (clk),
    .rst  (rst),
    .sclk (sclk),
    .cs_n (cs_n),
    .mosi (mosi),
`ifdef SPI_MEM_WR_PROTECT_EN
    .wp   (wp),
`endif
    .miso (miso),
    .done (done),
    .err  (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       op;
    logic [7:0] addr;
    logic [7:0] data;
    logic       exp_err;
    logic [7:0] exp_rd;
  } vec_t;

  typedef struct {
    logic       exp_err;
    logic       is_read;
    logic [7:0] exp_rd;
  } exp_t;

  exp_t       exp_q[$];
  vec_t       vecs[$];
  int         errors = 0;
  int         checks = 0;
  logic [7:0] rd_shift;
  logic       done_prev = 1'b0;

  function automatic void chk(string name, logic [7:0] act, logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_done(input logic e, input logic is_rd, input logic [7:0] rd);
    exp_t x;
    x.exp_err = e;
    x.is_read = is_rd;
    x.exp_rd  = rd;
    exp_q.push_back(x);
  endtask

  // Drives one frame of nbits (17 = complete); optional extra sclk pulses,
  // a long pause before bit stall_at, and a reset pulse during bit rst_at.
  task automatic frame(input logic op, input logic [7:0] a, input logic [7:0] d,
                       input int nbits, input int extra, input int stall_at, input int rst_at);
    logic [16:0] bits;
    bits     = {op, a, d};
    rd_shift = '0;
    cs_n     = 1'b0;
    wait_clk(8);
    for (int i = 0; i < nbits; i++) begin
      mosi = bits[16-i];
      if (i == stall_at) wait_clk(200);
      wait_clk(8);
      if (i >= 9) rd_shift = {rd_shift[6:0], miso};
      else chk("miso_low_in_addr", {7'd0, miso}, 8'h00);
      sclk = 1'b1;
      if (i == rst_at) begin
        #2 rst = 1'b0;
        #1;
        chk("rst_miso", {7'd0, miso}, 8'h00);
        chk("rst_done", {7'd0, done}, 8'h00);
        chk("rst_err",  {7'd0, err},  8'h00);
        wait_clk(3);
        rst = 1'b1;
      end
      wait_clk(8);
      sclk = 1'b0;
    end
    for (int j = 0; j < extra; j++) begin
      wait_clk(8);
      sclk = 1'b1;
      wait_clk(8);
      sclk = 1'b0;
    end
    wait_clk(8);
    cs_n = 1'b1;
    wait_clk(12);
    chk("miso_low_idle", {7'd0, miso}, 8'h00);
  endtask

  always @(negedge clk) begin
    if (err && !done) begin
      checks++; errors++;
      $display("FAIL err_without_done: err=1 done=0 at %0t", $time);
    end
    if (done && done_prev) begin
      checks++; errors++;
      $display("FAIL done_two_cycles: done=1 twice, required single pulse at %0t", $time);
    end
    if (done) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: done=1 err=%0b with no frame pending at %0t", err, $time);
      end else begin
        exp_t x;
        x = exp_q.pop_front();
        chk("done_err", {7'd0, err}, {7'd0, x.exp_err});
        if (x.is_read) chk("read_data", rd_shift, x.exp_rd);
      end
    end
    done_prev = done;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst  = 1'b0;
    sclk = 1'b0;
    cs_n = 1'b1;
    mosi = 1'b0;
`ifdef SPI_MEM_WR_PROTECT_EN
    wp   = 1'b0;
`endif
    wait_clk(5);
    chk("reset_miso", {7'd0, miso}, 8'h00);
    chk("reset_done", {7'd0, done}, 8'h00);
    chk("reset_err",  {7'd0, err},  8'h00);
    rst = 1'b1;
    wait_clk(5);

    vecs.push_back('{1'b0, 8'h1F, 8'h00, 1'b0, 8'h00});
    vecs.push_back('{1'b1, 8'h03, 8'hA5, 1'b0, 8'h00});
    vecs.push_back('{1'b0, 8'h03, 8'h00, 1'b0, 8'hA5});
    vecs.push_back('{1'b1, 8'h1F, 8'h5A, 1'b0, 8'h00});
    vecs.push_back('{1'b0, 8'h1F, 8'h00, 1'b0, 8'h5A});
    vecs.push_back('{1'b1, 8'h28, 8'hFF, 1'b1, 8'h00});
    vecs.push_back('{1'b0, 8'h28, 8'h00, 1'b1, 8'h00});
    vecs.push_back('{1'b1, 8'h20, 8'hC3, 1'b1, 8'h00});
    vecs.push_back('{1'b0, 8'h20, 8'h00, 1'b1, 8'h00});
    vecs.push_back('{1'b0, 8'hFF, 8'h00, 1'b1, 8'h00});
    vecs.push_back('{1'b0, 8'h03, 8'h00, 1'b0, 8'hA5});
    vecs.push_back('{1'b0, 8'h1F, 8'h00, 1'b0, 8'h5A});
    vecs.push_back('{1'b0, 8'h00, 8'h00, 1'b0, 8'h00});
    vecs.push_back('{1'b1, 8'h04, 8'h11, 1'b0, 8'h00});
    vecs.push_back('{1'b0, 8'h04, 8'h00, 1'b0, 8'h11});

    for (int v = 0; v < vecs.size(); v++) begin
      expect_done(vecs[v].exp_err, ~vecs[v].op, vecs[v].exp_rd);
      frame(vecs[v].op, vecs[v].addr, vecs[v].data, 17, 0, -1, -1);
    end

    // Abort after 5 bits of a write: error pulse, memory untouched.
    expect_done(1'b1, 1'b0, 8'h00);
    frame(1'b1, 8'h04, 8'hEE, 5, 0, -1, -1);
    expect_done(1'b0, 1'b1, 8'h11);
    frame(1'b0, 8'h04, 8'h00, 17, 0, -1, -1);

    // Abort mid read data phase.
    expect_done(1'b1, 1'b0, 8'h00);
    frame(1'b0, 8'h03, 8'h00, 12, 0, -1, -1);

    // Extra sclk edges after bit 17 give no second done.
    expect_done(1'b0, 1'b0, 8'h00);
    frame(1'b1, 8'h07, 8'h3C, 17, 3, -1, -1);
    expect_done(1'b0, 1'b1, 8'h3C);
    frame(1'b0, 8'h07, 8'h00, 17, 0, -1, -1);

    // Long pause with cs_n low mid-address.
    expect_done(1'b0, 1'b1, 8'hA5);
    frame(1'b0, 8'h03, 8'h00, 17, 0, 4, -1);

    // Reset during bit 12 of a write; rest of frame must be ignored.
    frame(1'b1, 8'h02, 8'h77, 17, 0, -1, 12);
    expect_done(1'b0, 1'b1, 8'h00);
    frame(1'b0, 8'h02, 8'h00, 17, 0, -1, -1);
    expect_done(1'b0, 1'b1, 8'h00);
    frame(1'b0, 8'h03, 8'h00, 17, 0, -1, -1);

`ifdef SPI_MEM_WR_PROTECT_EN
    wp = 1'b1;
    expect_done(1'b1, 1'b0, 8'h00);
    frame(1'b1, 8'h01, 8'h33, 17, 0, -1, -1);
    expect_done(1'b0, 1'b1, 8'h00);
    frame(1'b0, 8'h01, 8'h00, 17, 0, -1, -1);
    wp = 1'b0;
    expect_done(1'b0, 1'b0, 8'h00);
    frame(1'b1, 8'h01, 8'h33, 17, 0, -1, -1);
    expect_done(1'b0, 1'b1, 8'h33);
    frame(1'b0, 8'h01, 8'h00, 17, 0, -1, -1);
`endif

    wait_clk(20);
    chk("pending_done_count", 8'(exp_q.size()), 8'h00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
